// File: rtl/prim_mask_gen_pkg.sv
// Shared constants, state encoding and LFSR step function for the masking
// share generator.
package prim_mask_gen_pkg;

    localparam logic [31:0] LfsrPoly    = 32'h8000_0057;
    localparam logic [31:0] DefaultSeed = 32'h8BAD_F00D;

    typedef enum logic {
        MgUnseeded = 1'b0,
        MgRun      = 1'b1
    } mask_gen_state_e;

    // One Galois step: shift right, fold the polynomial in when the LSB falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] state);
        return (state >> 1) ^ (state[0] ? LfsrPoly : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/prim_mask_lfsr.sv
// 32-bit Galois LFSR with a seed load port and an advance enable.
// A zero seed is replaced by DefaultSeed so the register never locks up.
module prim_mask_lfsr
    import prim_mask_gen_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        seed_valid_i,
    input  logic [31:0] seed_i,
    input  logic        advance_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q;
    logic [31:0] seed_eff;

    assign seed_eff = (seed_i == 32'h0000_0000) ? DefaultSeed : seed_i;

    // A load takes priority over an advance in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= DefaultSeed;
        end else if (seed_valid_i) begin
            state_q <= seed_eff;
        end else if (advance_i) begin
            state_q <= lfsr_step(state_q);
        end
    end

    assign state_o = state_q;

`ifndef SYNTHESIS
    lfsr_nonzero_a: assert property (@(posedge clk_i) disable iff (rst_i)
        state_q != 32'h0000_0000);
`endif

endmodule

// File: rtl/prim_mask_gen.sv
// Two-share masking generator: share0 = data ^ mask, share1 = mask, with the
// mask drawn from a seeded LFSR and a use counter that forces periodic reseeds.
module prim_mask_gen
    import prim_mask_gen_pkg::*;
#(
    parameter int Width   = 32,
    parameter int MaxUses = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             seed_valid_i,
    input  logic [31:0]      seed_i,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [Width-1:0] share0_o,
    output logic [Width-1:0] share1_o,
    input  logic             ready_i,
    output logic             reseed_req_o,
    output logic             dbg_state_o
);

    // Handshake: a word moves on any edge where valid and ready are both high,
    // on the input side (valid_i/ready_o) and the output side (valid_o/ready_i)
    // alike; valid never waits on ready, and held outputs stay stable.
    localparam int              CntW   = $clog2(MaxUses + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxUses);

    mask_gen_state_e  state_q;
    logic [CntW-1:0]  count_q;
    logic             valid_q;
    logic [Width-1:0] share0_q;
    logic [Width-1:0] share1_q;

    logic [31:0]      lfsr_state;
    logic [Width-1:0] mask;
    logic             below_limit;
    logic             accept;

    assign mask        = lfsr_state[Width-1:0];
    assign below_limit = (count_q < MaxCnt);
    assign ready_o     = (state_q == MgRun) && below_limit && (!valid_q || ready_i);
    assign accept      = valid_i && ready_o;

    prim_mask_lfsr u_lfsr (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .seed_valid_i (seed_valid_i),
        .seed_i       (seed_i),
        .advance_i    (accept),
        .state_o      (lfsr_state)
    );

    // Accept is already gated by below_limit, so the counter saturates at MaxCnt.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= MgUnseeded;
            count_q  <= '0;
            valid_q  <= 1'b0;
            share0_q <= '0;
            share1_q <= '0;
        end else begin
            if (seed_valid_i) begin
                state_q <= MgRun;
            end

            if (seed_valid_i) begin
                count_q <= '0;
            end else if (accept) begin
                count_q <= count_q + CntW'(1);
            end

            if (accept) begin
                share0_q <= data_i ^ mask;
                share1_q <= mask;
                valid_q  <= 1'b1;
            end else if (ready_i) begin
                valid_q  <= 1'b0;
            end
        end
    end

    assign valid_o      = valid_q;
    assign share0_o     = share0_q;
    assign share1_o     = share1_q;
    assign reseed_req_o = (state_q == MgUnseeded) || (count_q == MaxCnt);
    assign dbg_state_o  = (state_q == MgRun);

`ifndef SYNTHESIS
    hold_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_q && !ready_i) |=> (valid_q && $stable(share0_q) && $stable(share1_q)));
`endif

endmodule

// File: tb/tb_prim_mask_gen.sv
// Bench for prim_mask_gen: directed scenarios plus a random phase, all checked
// against a cycle-level reference model and an expected-data queue.
module tb_prim_mask_gen;

    localparam int          Width   = 32;
    localparam int          MaxUses = 4;
    localparam logic [31:0] POLY    = 32'h8000_0057;
    localparam logic [31:0] DEF     = 32'h8BAD_F00D;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             seed_valid_i;
    logic [31:0]      seed_i;
    logic             valid_i;
    logic [Width-1:0] data_i;
    logic             ready_o;
    logic             valid_o;
    logic [Width-1:0] share0_o;
    logic [Width-1:0] share1_o;
    logic             ready_i;
    logic             reseed_req_o;
    logic             dbg_state_o;

    always #5 clk_i = ~clk_i;

    prim_mask_gen #(.Width(Width), .MaxUses(MaxUses)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .seed_valid_i (seed_valid_i),
        .seed_i       (seed_i),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .ready_o      (ready_o),
        .valid_o      (valid_o),
        .share0_o     (share0_o),
        .share1_o     (share1_o),
        .ready_i      (ready_i),
        .reseed_req_o (reseed_req_o),
        .dbg_state_o  (dbg_state_o)
    );

    int          checks = 0;
    int          errors = 0;
    int          acc_seen = 0;
    logic [31:0] exp_q[$];

    // Reference model state
    bit          m_seeded;
    bit          m_valid;
    int          m_count;
    logic [31:0] m_lfsr;
    logic [31:0] m_s0;
    logic [31:0] m_s1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        return (s >> 1) ^ (((s % 2) == 1) ? POLY : 32'h0);
    endfunction

    task automatic model_reset();
        m_seeded = 0;
        m_valid  = 0;
        m_count  = 0;
        m_lfsr   = DEF;
        m_s0     = '0;
        m_s1     = '0;
        exp_q.delete();
    endtask

    // One clock cycle: drive at negedge, check just after, update model, wait posedge.
    task automatic drive_cycle(input bit sv, input logic [31:0] seed, input bit v,
                               input logic [31:0] d, input bit rdy);
        bit          m_ready;
        logic [31:0] exp_d;
        @(negedge clk_i);
        seed_valid_i = sv;
        seed_i       = seed;
        valid_i      = v;
        data_i       = d;
        ready_i      = rdy;
        #1;
        m_ready = m_seeded && (m_count < MaxUses) && (!m_valid || rdy);
        check_eq("ready", 32'(ready_o), 32'(m_ready));
        check_eq("reseed", 32'(reseed_req_o), 32'(!m_seeded || (m_count == MaxUses)));
        check_eq("valid", 32'(valid_o), 32'(m_valid));
        check_eq("state", 32'(dbg_state_o), 32'(m_seeded));
        if (m_valid) begin
            check_eq("share0", share0_o, m_s0);
            check_eq("share1", share1_o, m_s1);
        end
        if (valid_o && rdy) begin
            check_eq("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_d = exp_q.pop_front();
                check_eq("recombine", share0_o ^ share1_o, exp_d);
            end
        end
        if (v && ready_o) acc_seen++;
        if (v && m_ready) begin
            m_s0    = d ^ m_lfsr;
            m_s1    = m_lfsr;
            m_valid = 1;
            exp_q.push_back(d);
        end else if (rdy) begin
            m_valid = 0;
        end
        if (sv) begin
            m_lfsr   = (seed == 0) ? DEF : seed;
            m_count  = 0;
            m_seeded = 1;
        end else if (v && m_ready) begin
            m_lfsr  = ref_step(m_lfsr);
            m_count = m_count + 1;
        end
        @(posedge clk_i);
    endtask

    logic [31:0] s_tmp;
    logic [31:0] old_mask;

    initial begin
        seed_valid_i = 0;
        seed_i       = '0;
        valid_i      = 0;
        data_i       = '0;
        ready_i      = 0;
        model_reset();

        @(negedge clk_i);
        check_eq("rst_valid", 32'(valid_o), 32'd0);
        check_eq("rst_share0", share0_o, 32'd0);
        check_eq("rst_share1", share1_o, 32'd0);
        check_eq("rst_ready", 32'(ready_o), 32'd0);
        check_eq("rst_reseed", 32'(reseed_req_o), 32'd1);
        rst_i = 0;

        // Unseeded gating
        acc_seen = 0;
        repeat (6) drive_cycle(0, 0, 1, $urandom, 1);
        check_eq("gate_acc", acc_seen, 0);

        // Basic masking
        drive_cycle(1, 32'h0000_0001, 0, 0, 1);
        drive_cycle(0, 0, 1, 32'hDEAD_BEEF, 1);
        #1;
        check_eq("basic_s1", share1_o, 32'h0000_0001);
        check_eq("basic_s0", share0_o, 32'hDEAD_BEEE);
        drive_cycle(0, 0, 1, 32'h1234_5678, 1);
        #1;
        check_eq("basic_mask2", share1_o, 32'h8000_0057);

        // Zero seed
        drive_cycle(1, 32'h0, 0, 0, 1);
        drive_cycle(0, 0, 1, $urandom, 1);
        #1;
        check_eq("zero_seed", share1_o, DEF);

        // Backpressure
        s_tmp = $urandom | 32'h1;
        drive_cycle(1, s_tmp, 0, 0, 1);
        acc_seen = 0;
        repeat (5) drive_cycle(0, 0, 1, $urandom, 0);
        check_eq("bp_acc", acc_seen, 1);
        drive_cycle(0, 0, 1, $urandom, 1);
        #1;
        check_eq("bp_step_once", share1_o, ref_step(s_tmp));
        acc_seen = 0;
        repeat (3) drive_cycle(0, 0, 1, $urandom, 1);
        check_eq("bp_stream", acc_seen, 2);

        // Use limit
        drive_cycle(1, $urandom, 0, 0, 1);
        acc_seen = 0;
        repeat (6) drive_cycle(0, 0, 1, $urandom, 1);
        check_eq("limit_acc", acc_seen, MaxUses);
        #1;
        check_eq("limit_ready", 32'(ready_o), 32'd0);
        check_eq("limit_reseed", 32'(reseed_req_o), 32'd1);
        acc_seen = 0;
        drive_cycle(1, $urandom, 1, $urandom, 1);
        check_eq("reseed_cycle_acc", acc_seen, 0);
        drive_cycle(0, 0, 1, $urandom, 1);
        check_eq("resume_acc", acc_seen, 1);

        // Seed/accept collision
        old_mask = m_lfsr;
        s_tmp    = $urandom | 32'h2;
        drive_cycle(1, s_tmp, 1, $urandom, 1);
        #1;
        check_eq("col_old_mask", share1_o, old_mask);
        acc_seen = 0;
        drive_cycle(0, 0, 1, $urandom, 1);
        #1;
        check_eq("col_new_mask", share1_o, s_tmp);
        repeat (5) drive_cycle(0, 0, 1, $urandom, 1);
        check_eq("col_count_zero", acc_seen, MaxUses);

        // Asynchronous reset mid-transfer
        drive_cycle(1, $urandom, 0, 0, 1);
        drive_cycle(0, 0, 1, $urandom, 0);
        @(negedge clk_i);
        #2 rst_i = 1;
        #1;
        check_eq("arst_valid", 32'(valid_o), 32'd0);
        check_eq("arst_share0", share0_o, 32'd0);
        check_eq("arst_reseed", 32'(reseed_req_o), 32'd1);
        model_reset();
        @(negedge clk_i);
        rst_i = 0;

        // Random phase
        repeat (400) begin
            drive_cycle($urandom_range(0, 15) == 0,
                        ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                        1'($urandom_range(0, 1)), $urandom,
                        $urandom_range(0, 3) != 0);
        end
        drive_cycle(0, 0, 0, 0, 1);
        check_eq("sb_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prim_mask_gen.md
# prim_mask_gen

Masking share generator feeding `prim_generic_xor2` recombination points. Takes unmasked words over a valid/ready handshake and emits a registered two-share encoding: share0 = data XOR mask, share1 = mask. The mask comes from an internal 32-bit Galois LFSR that must be seeded before use. A use counter requests a reseed after a fixed number of masks.

## Interface
- `Width`, 32: data/share width; legal range 1..32.
- `MaxUses`, 1024: masks issued per seed before the block stalls; must be ≥1.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `seed_valid_i`  in  1  load `seed_i` into the LFSR this cycle.
- `seed_i`  in  32  LFSR seed.
- `valid_i`  in  1  input word valid.
- `data_i`  in  Width  unmasked input word.
- `ready_o`  out  1  block accepts the input word this cycle.
- `valid_o`  out  1  output shares valid.
- `share0_o`  out  Width  data XOR mask.
- `share1_o`  out  Width  mask.
- `ready_i`  in  1  downstream accepts the output shares.
- `reseed_req_o`  out  1  block needs a seed (it is unseeded or has reached `MaxUses`).

## Operation
- States are Unseeded and Run.
  - Reset enters Unseeded.
  - Any `seed_valid_i` moves the block to Run.
  - There is no path back to Unseeded except reset.
- Seed load:
  - LFSR ← `seed_i`. If `seed_i` == 0, load `DefaultSeed` (0x8BAD_F00D) instead, because the all-zero state is the LFSR lockup state.
  - The use counter clears to 0.
- LFSR:
  - Galois form, polynomial constant `LfsrPoly` = 0x8000_0057.
  - Advance: state = (state >> 1) XOR (state[0] ? LfsrPoly : 0).
  - The mask is the current state[Width-1:0].
- Accept condition: accept = `valid_i` && `ready_o`.
- `ready_o` = Run && (count < `MaxUses`) && (!`valid_o` || `ready_i`).
- On accept:
  - Capture `share0_o` = `data_i` ^ mask and `share1_o` = mask.
  - Set `valid_o`.
  - Advance the LFSR one step.
  - Increment the counter.
- Output: `valid_o` clears when the output is consumed (`ready_i` high) with no new accept in the same cycle. While `valid_o` && !`ready_i`, the shares hold stable.
- Counter:
  - Width is $clog2(MaxUses+1) bits.
  - It saturates at `MaxUses`.
  - At `MaxUses`, `ready_o` goes low and any pending output still drains normally.
- `reseed_req_o` = Unseeded || (count == `MaxUses`). It is combinational from registered state.
- Seed and accept in the same cycle:
  - The accepted word uses the old mask.
  - The LFSR then loads the seed (seed wins over advance).
  - The counter goes to 0, not 1.
- Seed while Unseeded: `ready_o` stays low in that cycle and rises the following cycle.

## Timing
- Latency: an input accepted at edge N appears on the outputs after edge N, valid in cycle N+1.
- Throughput is one word per cycle when `ready_i` is held high.
- No combinational path from `valid_i` or `data_i` to any output. `ready_o` depends combinationally on `ready_i`.
- Reset values:
  - `valid_o` = 0, `share0_o` = 0, `share1_o` = 0.
  - `ready_o` = 0, `reseed_req_o` = 1.
  - LFSR = `DefaultSeed`, counter = 0.
- Reset asserted mid-transfer drops `valid_o` immediately (asynchronous). Any pending shares are lost.

## Structure
- `prim_mask_gen_pkg` holds:
  - `LfsrPoly`, `DefaultSeed`;
  - the state enum `mask_gen_state_e` {MgUnseeded, MgRun};
  - the function `lfsr_step(logic [31:0])`.
- Sub-module `prim_mask_lfsr` contains the 32-bit register with a load port (`seed_valid_i`, `seed_i`) and an advance enable. It maps zero seeds to `DefaultSeed`.
- Top level contains the FSM, counter, output register and handshake logic.
- Assertions:
  - `share0_o ^ share1_o` equals the accepted data, checked against a scoreboard.
  - Outputs are stable while `valid_o` && !`ready_i`.
  - The LFSR is never 0.

## Test plan
- **Reset and gating:** drive `valid_i`=1 with no seed → `ready_o`=0, `reseed_req_o`=1, `valid_o`=0 indefinitely.
- **Basic masking:** seed 0x0000_0001, Width=32, send 0xDEAD_BEEF → next cycle `share1_o`=0x0000_0001, `share0_o`=0xDEAD_BEEE. The second word's mask is 0x8000_0057.
- **Zero seed:** seed 0 → first `share1_o` = 0x8BAD_F00D.
- **Backpressure:**
  - Stimulus: hold `ready_i`=0 for 5 cycles with `valid_i`=1.
  - Required response: the shares hold, only one word is accepted, and the LFSR advances once.
  - After release: one word per cycle, each XOR-recombining correctly.
- **Use limit:**
  - Stimulus: `MaxUses`=4, stream 6 words.
  - Required response: 4 words are accepted, then `ready_o`=0 and `reseed_req_o`=1.
  - A reseed clears the request and acceptance resumes the next cycle.
- **Seed/accept collision:** assert seed and an accepted word in the same cycle → the word uses the old mask, the next word uses the new seed, and the counter reads 0 after the edge.
